// File: rtl/cell_display_reader.sv
// VGA timing generator that streams the cell buffer out as RGB444 pixels and
// requests one next-state update per frame, flagging frames where it is late.
module cell_display_reader #(
    parameter int          ACTIVE_COLUMNS = 640,
    parameter int          ACTIVE_ROWS    = 480,
    parameter int          H_FRONT        = 16,
    parameter int          H_SYNC         = 96,
    parameter int          H_BACK         = 48,
    parameter int          V_FRONT        = 10,
    parameter int          V_SYNC         = 2,
    parameter int          V_BACK         = 33,
    parameter int          ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
    parameter int          DATA_WIDTH     = 1,
    parameter logic [11:0] CELL_COLOR     = 12'hFC8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  pix_tick_i,
    input  logic [DATA_WIDTH-1:0] pixel_state_i,
    output logic [ADDR_WIDTH-1:0] read_address_o,
    input  logic                  update_done_i,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  video_on_o,
    output logic [11:0]           rgb_o,
    output logic                  update_ready_o,
    output logic                  frame_start_o,
    output logic                  overrun_o,
    output logic [7:0]            overrun_count_o
);

    localparam int H_TOTAL      = ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = ACTIVE_COLUMNS + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = ACTIVE_ROWS + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    // One spare bit so the sync-window end always fits even with a zero back porch.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    typedef enum logic {
        UPD_IDLE,
        UPD_BUSY
    } upd_state_t;

    upd_state_t    upd_state_reg;
    logic [HW-1:0] h_count_reg;
    logic [VW-1:0] v_count_reg;

    logic          h_last;
    logic          v_last;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          active;
    logic          next_active;
    logic          next_origin;
    logic          frame_origin;
    logic          hsync_now;
    logic          vsync_now;
    logic          vblank_start;
    logic          busy_after_done;

    always_comb begin
        h_last       = (h_count_reg == HW'(H_TOTAL - 1));
        v_last       = (v_count_reg == VW'(V_TOTAL - 1));
        h_next       = h_last ? '0 : h_count_reg + HW'(1);
        v_next       = v_count_reg;
        if (h_last) begin
            v_next = v_last ? '0 : v_count_reg + VW'(1);
        end
        active       = (h_count_reg < HW'(ACTIVE_COLUMNS)) && (v_count_reg < VW'(ACTIVE_ROWS));
        next_active  = (h_next < HW'(ACTIVE_COLUMNS)) && (v_next < VW'(ACTIVE_ROWS));
        next_origin  = (h_next == '0) && (v_next == '0);
        frame_origin = (h_count_reg == '0) && (v_count_reg == '0);
        hsync_now    = !((h_count_reg >= HW'(H_SYNC_START)) && (h_count_reg < HW'(H_SYNC_END)));
        vsync_now    = !((v_count_reg >= VW'(V_SYNC_START)) && (v_count_reg < VW'(V_SYNC_END)));
        vblank_start = pix_tick_i && h_last && (v_count_reg == VW'(ACTIVE_ROWS - 1));
        // A done arriving on the vblank-start clock frees the engine in time for a new request.
        busy_after_done = (upd_state_reg == UPD_BUSY) && !update_done_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            upd_state_reg   <= UPD_IDLE;
            h_count_reg     <= '0;
            v_count_reg     <= '0;
            read_address_o  <= '0;
            hsync_o         <= 1'b1;
            vsync_o         <= 1'b1;
            video_on_o      <= 1'b0;
            rgb_o           <= '0;
            update_ready_o  <= 1'b0;
            frame_start_o   <= 1'b0;
            overrun_o       <= 1'b0;
            overrun_count_o <= '0;
        end else begin
            update_ready_o <= 1'b0;
            frame_start_o  <= 1'b0;
            overrun_o      <= 1'b0;

            if (vblank_start && !busy_after_done) begin
                update_ready_o <= 1'b1;
                upd_state_reg  <= UPD_BUSY;
            end else if (update_done_i) begin
                upd_state_reg  <= UPD_IDLE;
            end

            if (pix_tick_i) begin
                h_count_reg <= h_next;
                v_count_reg <= v_next;
                // Advancing only when entering a visible pixel keeps the address in range.
                if (next_origin) begin
                    read_address_o <= '0;
                end else if (next_active) begin
                    read_address_o <= read_address_o + ADDR_WIDTH'(1);
                end

                video_on_o <= active;
                hsync_o    <= hsync_now;
                vsync_o    <= vsync_now;
                rgb_o      <= (active && (pixel_state_i != '0)) ? CELL_COLOR : 12'h000;

                if (frame_origin) begin
                    frame_start_o <= 1'b1;
                    if (upd_state_reg == UPD_BUSY) begin
                        overrun_o <= 1'b1;
                        if (overrun_count_o != 8'hFF) begin
                            overrun_count_o <= overrun_count_o + 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cell_display_reader.sv
// Scoreboard bench for cell_display_reader on a reduced 8x4 raster (11x7 total).
`timescale 1ns/1ps
module tb_cell_display_reader;

    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int HT    = 11;
    localparam int VT    = 7;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        pix_tick = 1'b0;
    logic        update_done = 1'b0;
    logic [0:0]  pixel_state = 1'b0;
    logic [4:0]  read_address;
    logic        hsync, vsync, video_on, update_ready, frame_start, overrun;
    logic [11:0] rgb;
    logic [7:0]  overrun_count;

    always #5 clk = ~clk;

    cell_display_reader #(
        .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS),
        .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .pix_tick_i(pix_tick),
        .pixel_state_i(pixel_state), .read_address_o(read_address),
        .update_done_i(update_done), .hsync_o(hsync), .vsync_o(vsync),
        .video_on_o(video_on), .rgb_o(rgb), .update_ready_o(update_ready),
        .frame_start_o(frame_start), .overrun_o(overrun),
        .overrun_count_o(overrun_count)
    );

    // Buffer model: data for an address issued at one edge is ready for the next.
    logic cells [0:COLS*ROWS-1];
    always @(negedge clk) pixel_state <= cells[read_address];

    typedef struct packed {
        logic        von, hs, vs, fs, ur, ov;
        logic [7:0]  oc;
        logic [11:0] rgb;
        logic [4:0]  addr;
    } exp_t;

    localparam exp_t RESET_EXP = '{von:1'b0, hs:1'b1, vs:1'b1, fs:1'b0, ur:1'b0, ov:1'b0,
                                   oc:8'd0, rgb:12'h000, addr:5'd0};

    exp_t exp_q[$];
    exp_t last_exp = RESET_EXP;
    int   checks = 0;
    int   failures = 0;
    int   model_addr = 0;
    int   model_oc = 0;
    logic tick_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cmp(input exp_t e);
        check("video_on", 32'(video_on), 32'(e.von));
        check("hsync", 32'(hsync), 32'(e.hs));
        check("vsync", 32'(vsync), 32'(e.vs));
        check("rgb", 32'(rgb), 32'(e.rgb));
        check("read_address", 32'(read_address), 32'(e.addr));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("update_ready", 32'(update_ready), 32'(e.ur));
        check("overrun", 32'(overrun), 32'(e.ov));
        check("overrun_count", 32'(overrun_count), 32'(e.oc));
    endtask

    // Monitor: pops one expectation per pixel tick; between ticks outputs must hold.
    always @(posedge clk) tick_q <= pix_tick && !reset_i;

    always @(negedge clk) begin
        exp_t e;
        if (reset_i) begin
            last_exp = RESET_EXP;
        end else if (tick_q) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                cmp(e);
                last_exp = e;
                if (e.fs)
                    $display("frame_start t=%0t overrun=%0b overrun_count=%0d", $time, overrun, overrun_count);
            end
        end else begin
            e = last_exp;
            e.fs = 1'b0;
            e.ur = 1'b0;
            e.ov = 1'b0;
            cmp(e);
        end
    end

    // Expected registered outputs for the tick that samples raster position p.
    task automatic push_exp(input int p, input logic ur, input logic ov);
        exp_t e;
        int h, v, qh, qv;
        logic act;
        h   = p % HT;
        v   = p / HT;
        act = (h < COLS) && (v < ROWS);
        e.von = act;
        e.hs  = (h != 9);
        e.vs  = (v != 5);
        e.fs  = (p == 0);
        e.rgb = 12'h000;
        if (act && cells[v*COLS + h]) e.rgb = 12'hFC8;
        qh = ((p + 1) % FRAME) % HT;
        qv = ((p + 1) % FRAME) / HT;
        if (qh < COLS && qv < ROWS) model_addr = qv*COLS + qh;
        e.addr = 5'(model_addr);
        if (ov && model_oc != 255) model_oc++;
        e.oc = 8'(model_oc);
        e.ur = ur;
        e.ov = ov;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state();
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_video_on", 32'(video_on), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_read_address", 32'(read_address), 32'd0);
        check("rst_update_ready", 32'(update_ready), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_overrun_count", 32'(overrun_count), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i  = 1'b1;
        pix_tick = 1'b1;
        #1;
        check_reset_state();
        @(negedge clk);
        @(negedge clk);
        check_reset_state();
        exp_q.delete();
        model_addr  = 0;
        model_oc    = 0;
        pix_tick    = 1'b0;
        update_done = 1'b0;
        reset_i     = 1'b0;
    endtask

    // id 0: done 10 ticks after each request (plus a stray done while idle)
    // id 1: engine never answers; id 2: done lands on the vblank-start clock
    task automatic run_scenario(input int id, input int nticks, input int gap);
        logic done, ur, ov;
        int p, f;
        for (int t = 0; t < nticks; t++) begin
            p = t % FRAME;
            f = t / FRAME;
            case (id)
                0: begin
                    done = (f == 0 && p == 20) || (p == 53);
                    ur   = (p == 43);
                    ov   = 1'b0;
                end
                1: begin
                    done = 1'b0;
                    ur   = (f == 0 && p == 43);
                    ov   = (f >= 1 && p == 0);
                end
                default: begin
                    done = (f == 1 && p == 43) || (f >= 1 && p == 53);
                    ur   = (p == 43);
                    ov   = (f == 1 && p == 0);
                end
            endcase
            push_exp(p, ur, ov);
            pix_tick    = 1'b1;
            update_done = done;
            @(negedge clk);
            pix_tick    = 1'b0;
            update_done = 1'b0;
            repeat (gap) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("scenario %0d done ticks=%0d gap=%0d checks=%0d", id, nticks, gap, checks);
    endtask

    initial begin
        for (int i = 0; i < COLS*ROWS; i++) cells[i] = 1'b0;
        cells[0] = 1'b1;
        cells[9] = 1'b1;

        do_reset();
        run_scenario(0, 2*FRAME + 30, 0);
        do_reset();
        run_scenario(2, 3*FRAME + 30, 0);
        do_reset();
        run_scenario(0, 2*FRAME + 30, 3);
        do_reset();
        run_scenario(1, 262*FRAME + 5, 0);
        check("saturated_count", 32'(overrun_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/cell_display_reader.md
Name: cell_display_reader

Overview:
- Read-side counterpart of the cell next-state engine.
- Generates VGA 640x480 timing and streams the cell buffer out sequentially through the buffer's display read port, converting each cell bit to RGB.
- Issues the per-frame update request (the engine's ready input) at vblank start and tracks its completion (the engine's done output) to flag frame overruns.

Parameters:
- ACTIVE_COLUMNS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell address width
- DATA_WIDTH, 1, cell width; nonzero = occupied
- CELL_COLOR, 12'hFC8, RGB444 colour for occupied cells; empty cells are 12'h000

Ports:
- clk_i, input, 1, system clock
- reset_i, input, 1, asynchronous active-high reset
- pix_tick_i, input, 1, pixel enable; one-clk pulse per pixel period (may be tied high)
- pixel_state_i, input, DATA_WIDTH, buffer read data; valid exactly 1 clk after read_address_o
- read_address_o, output, ADDR_WIDTH, buffer read address (registered)
- update_done_i, input, 1, one-clk completion pulse from the next-state engine
- hsync_o, output, 1, horizontal sync, active low
- vsync_o, output, 1, vertical sync, active low
- video_on_o, output, 1, high during visible pixels
- rgb_o, output, 12, RGB444 pixel
- update_ready_o, output, 1, one-clk update request to the next-state engine
- frame_start_o, output, 1, one-clk pulse on the first visible pixel tick of each frame
- overrun_o, output, 1, one-clk pulse when an update is still busy at frame start
- overrun_count_o, output, 8, saturating overrun counter

Behaviour:
- Reset: hsync_o=1, vsync_o=1, video_on_o=0, rgb_o=0, read_address_o=0, update_ready_o=0, frame_start_o=0, overrun_o=0, overrun_count_o=0, h/v counters=0, busy=0.
- Reset is honoured mid-frame or mid-update; busy clears and no pulse is emitted on the reset clock.
- Counters:
  - h_count 0..H_TOTAL-1, where H_TOTAL = ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK.
  - v_count 0..V_TOTAL-1, defined analogously.
  - Counters advance only on pix_tick_i; h wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1.
- Active region: h_count < ACTIVE_COLUMNS and v_count < ACTIVE_ROWS.
- Sync windows:
  - hsync low for h in [ACTIVE_COLUMNS+H_FRONT, ACTIVE_COLUMNS+H_FRONT+H_SYNC).
  - vsync low for v in the analogous vertical window.
- Addressing:
  - A running address register is used; no multiplier.
  - read_address_o equals the linear index v_count*ACTIVE_COLUMNS + h_count of the current counter position.
  - It increments on each active pix_tick_i and resets to 0 on the tick that enters (h=0, v=0).
  - Outside the active region it holds the last value, or 0 after the frame wrap.
- Pipeline (one pixel tick of latency):
  - On each pix_tick_i, register the previous position's outputs: video_on_o, hsync_o, vsync_o, and rgb_o.
  - rgb_o = CELL_COLOR if active and pixel_state_i != 0, else 0.
  - pixel_state_i is sampled at that tick; correctness requires pix_tick spacing >= 1 clk, which holds with pix_tick tied high.
  - Sync and video_on are delayed the same amount so they stay aligned.
- Outputs change only on pix_tick_i clocks.
- frame_start_o: pulses on the tick whose registered outputs correspond to (h=0, v=0).
- Update handshake:
  - vblank start is the pix_tick_i where counters enter (h=0, v=ACTIVE_ROWS).
  - At vblank start with busy=0: update_ready_o pulses 1 clk and busy is set.
  - At vblank start with busy=1: no request is issued; the frame is skipped.
  - update_done_i with busy=1: clears busy next clk. update_done_i with busy=0 is ignored.
  - If update_done_i coincides with vblank start while busy: done wins, busy=0, and a new request is issued the same clk, so busy is set again.
- Overrun:
  - On the frame_start_o tick, if busy=1: overrun_o pulses and overrun_count_o increments, saturating at 255.
  - No increment beyond 255.
- The block never writes the buffer. Read address is never >= ACTIVE_COLUMNS*ACTIVE_ROWS.

Test Plan:
- Reset mid-frame (ACTIVE 8x4, porches 1/1/1, pix_tick high), release -> all outputs at reset values; counters restart at (0,0); first read_address_o sequence is 0,1,...,7 then 8 on line 1.
- Preload cells 0 and 9 = 1, others 0 (8x4 params) -> rgb_o=12'hFC8 exactly on the registered pixels (0,0) and (1,1), 0 elsewhere; video_on_o high 8 ticks per line for 4 lines.
- pix_tick_i every 4th clk with default 640x480 params -> hsync low 96 ticks starting at tick 656 of each line; vsync low during lines 490-491; line period 800 ticks, frame period 525 lines.
- Engine answers update_done_i 10 clks after update_ready_o -> exactly one update_ready_o per frame; overrun_o never asserts; overrun_count_o stays 0.
- update_done_i never asserted -> first frame issues one request; next frame_start_o pulses overrun_o; update_ready_o not reissued; overrun_count_o saturates at 255 after 255+ frames.
- update_done_i on the same clk as vblank start while busy -> update_ready_o pulses that clk; busy remains set; no overrun at the next frame start if done follows.
